// File: rtl/serializer_pkg.sv
// Shared types and constants for the word serializer.
// Holds the FSM state enum, counter widths and the words_sent width.
package serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PAR,
        ST_GAP
    } state_t;

    localparam int WS_W  = 16;
    localparam int GAP_W = 4;
    localparam int CNT_W = $clog2(8);

    // Bit counter width for a given word width (holds WIDTH-1).
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// WIDTH-bit load/shift-left register with even-parity capture.
// Ports: clk, areset_n, i_load, i_shift, i_data -> o_tap (next MSB), o_parity.
module serial_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_tap,
    output logic             o_parity
);

    logic [WIDTH-1:0] r_shreg;
    logic             r_par;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_shreg <= '0;
            r_par   <= 1'b0;
        end else if (i_load) begin
            r_shreg <= i_data;
            r_par   <= ^i_data;
        end else if (i_shift) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
        end
    end

    // Bit that will sit at the MSB after this edge; lets the top
    // register serial_out without an extra cycle of latency.
    assign o_tap    = i_load ? i_data[WIDTH-1] : r_shreg[WIDTH-2];
    assign o_parity = r_par;

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: MSB-first stream, optional parity, idle gap.
// Ports: clk, areset_n, in_data/in_valid/in_ready, serial_out/serial_valid, busy, words_sent.
module word_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int GAP       = 1,
    parameter int PARITY_EN = 0
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic [WS_W-1:0]  words_sent
);

    localparam int              CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam bit              HAS_PAR  = (PARITY_EN != 0);
    localparam bit              HAS_GAP  = (GAP > 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] w_gap_nxt;
    logic             r_sout;
    logic             r_svalid;
    logic             r_busy;
    logic [WS_W-1:0]  r_words_sent;

    logic w_load;
    logic w_shift;
    logic w_done;
    logic w_last;
    logic w_ready;
    logic w_accept;
    logic w_tap;
    logic w_par;
    logic w_sout_nxt;

    serial_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk      (clk),
        .areset_n (areset_n),
        .i_load   (w_load),
        .i_shift  (w_shift),
        .i_data   (in_data),
        .o_tap    (w_tap),
        .o_parity (w_par)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        // Final serial cycle of a word: last data bit, or the parity bit.
        w_last = (r_state == ST_PAR) ||
                 ((r_state == ST_SHIFT) && (r_cnt == '0) && !HAS_PAR);
        // Back-to-back accept only when no gap is configured.
        w_ready  = (r_state == ST_IDLE) || (!HAS_GAP && w_last);
        w_accept = in_valid && w_ready;

        unique case (r_state)
            ST_IDLE: ;
            ST_SHIFT: begin
                if (r_cnt != '0) begin
                    w_shift   = 1'b1;
                    w_cnt_nxt = r_cnt - CW'(1);
                end else begin
                    w_done = !HAS_PAR;
                    if (HAS_PAR) begin
                        w_state_nxt = ST_PAR;
                    end else if (HAS_GAP) begin
                        w_state_nxt = ST_GAP;
                        w_gap_nxt   = GAP_INIT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_PAR: begin
                w_done = 1'b1;
                if (HAS_GAP) begin
                    w_state_nxt = ST_GAP;
                    w_gap_nxt   = GAP_INIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gap == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap - GAP_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_accept) begin
            w_load      = 1'b1;
            w_shift     = 1'b0;
            w_cnt_nxt   = LAST_IDX;
            w_state_nxt = ST_SHIFT;
        end

        unique case (w_state_nxt)
            ST_SHIFT: w_sout_nxt = w_tap;
            ST_PAR:   w_sout_nxt = w_par;
            default:  w_sout_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_gap        <= '0;
            r_sout       <= 1'b0;
            r_svalid     <= 1'b0;
            r_busy       <= 1'b0;
            r_words_sent <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_gap    <= w_gap_nxt;
            r_sout   <= w_sout_nxt;
            r_svalid <= (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_PAR);
            r_busy   <= (w_state_nxt != ST_IDLE);
            if (w_done) begin
                r_words_sent <= r_words_sent + WS_W'(1);
            end
        end
    end

    assign in_ready     = w_ready;
    assign serial_out   = r_sout;
    assign serial_valid = r_svalid;
    assign busy         = r_busy;
    assign words_sent   = r_words_sent;

endmodule
